// File: rtl/scan_alu_test_ctrl_if.sv
// Vector handshake bundle between a test-vector source and scan_alu_test_ctrl.
// master = vector source, slave = controller.
interface scan_alu_test_ctrl_if #(
  parameter int DATA_W = 4,
  parameter int OP_W   = 3
);
  logic              vec_valid;
  logic              vec_ready;
  logic [DATA_W-1:0] vec_a;
  logic [DATA_W-1:0] vec_b;
  logic [OP_W-1:0]   vec_op;
  logic [DATA_W-1:0] vec_exp_res;
  logic              vec_exp_zero;

  modport master (
    output vec_valid, vec_a, vec_b, vec_op, vec_exp_res, vec_exp_zero,
    input  vec_ready
  );

  modport slave (
    input  vec_valid, vec_a, vec_b, vec_op, vec_exp_res, vec_exp_zero,
    output vec_ready
  );
endinterface

// File: rtl/scan_alu_test_ctrl.sv
// Scan-ALU test sequencer: shifts {A,B} MSB first into the ALU scan chain,
// captures and checks the ALU outputs, and keeps saturating pass/fail counters.
module scan_alu_test_ctrl #(
  parameter int DATA_W = 4,
  parameter int OP_W   = 3,
  parameter int CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  scan_alu_test_ctrl_if.slave  vec,
  output logic                 scan_enable,
  output logic                 scan_in,
  output logic [OP_W-1:0]      alu_opcode,
  input  logic [DATA_W-1:0]    alu_result,
  input  logic                 alu_zero,
  input  logic                 clr_cnt,
  output logic                 busy,
  output logic                 res_valid,
  output logic                 res_pass,
  output logic [DATA_W-1:0]    res_value,
  output logic [CNT_W-1:0]     pass_cnt,
  output logic [CNT_W-1:0]     fail_cnt
);

  localparam int CH_LEN = 2 * DATA_W;
  localparam int KW     = $clog2(CH_LEN);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    CAPTURE = 2'd2,
    REPORT  = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic              accept;
  logic [CH_LEN-1:0] pat;
  logic [KW-1:0]     k;
  logic [DATA_W-1:0] exp_res;
  logic              exp_zero;

  assign vec.vec_ready = (state == IDLE);
  assign busy          = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    unique case (state)
      IDLE: begin
        if (vec.vec_valid) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT:   if (k == KW'(CH_LEN - 1)) state_nxt = CAPTURE;
      CAPTURE: state_nxt = REPORT;
      REPORT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // scan_in is the registered MSB of the pattern; pat is preloaded one bit ahead,
  // so zeros have filled it by CAPTURE and scan_in drops to 0 there for free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pat         <= '0;
      k           <= '0;
      exp_res     <= '0;
      exp_zero    <= 1'b0;
      alu_opcode  <= '0;
      scan_enable <= 1'b0;
      scan_in     <= 1'b0;
      res_valid   <= 1'b0;
      res_pass    <= 1'b0;
      res_value   <= '0;
    end else begin
      scan_enable <= (state_nxt == SHIFT) || (state_nxt == CAPTURE);
      res_valid   <= (state_nxt == REPORT);
      if (accept) begin
        pat        <= {vec.vec_a, vec.vec_b} << 1;
        scan_in    <= vec.vec_a[DATA_W-1];
        k          <= '0;
        exp_res    <= vec.vec_exp_res;
        exp_zero   <= vec.vec_exp_zero;
        alu_opcode <= vec.vec_op;
      end else if (state == SHIFT) begin
        scan_in <= pat[CH_LEN-1];
        pat     <= pat << 1;
        k       <= k + 1'b1;
      end else if (state == CAPTURE) begin
        res_value <= alu_result;
        res_pass  <= (alu_result == exp_res) && (alu_zero == exp_zero);
      end
    end
  end

  // Clear has priority over a same-cycle increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
    end else if (clr_cnt) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
    end else if (state == REPORT) begin
      if (res_pass) begin
        if (pass_cnt != '1) pass_cnt <= pass_cnt + 1'b1;
      end else begin
        if (fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
      end
    end
  end

endmodule
